// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with 2-entry skid buffer, flush and bubble gating.
// Optional perf counters enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 16,
    parameter int DST_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DST_W-1:0]  in_dst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [DST_W-1:0]  out_dst
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CTRL_W-1:0]   r_m_ctrl;
    logic [DATA_W-1:0]   r_m_data;
    logic [DST_W-1:0]    r_m_dst;
    logic [CTRL_W-1:0]   r_s_ctrl;
    logic [DATA_W-1:0]   r_s_data;
    logic [DST_W-1:0]    r_s_dst;
    logic                w_acc;
    logic                w_drn;
    logic                w_ld_m_in;
    logic                w_ld_s_in;
    logic                w_m_from_s;

    // in_ready is a pure decode of the state register: no in->out comb path
    assign in_ready  = (r_state != ST_TWO);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_acc     = in_valid && in_ready;
    assign w_drn     = out_valid && out_ready;

    assign out_ctrl  = out_valid ? r_m_ctrl : '0;
    assign out_data  = r_m_data;
    assign out_dst   = r_m_dst;

    always_comb begin
        w_state_nxt = r_state;
        w_ld_m_in   = 1'b0;
        w_ld_s_in   = 1'b0;
        w_m_from_s  = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_acc) begin
                    w_ld_m_in   = 1'b1;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_acc && w_drn) begin
                    w_ld_m_in = 1'b1;
                end else if (w_acc) begin
                    w_ld_s_in   = 1'b1;
                    w_state_nxt = ST_TWO;
                end else if (w_drn) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_drn) begin
                    w_m_from_s  = 1'b1;
                    w_state_nxt = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Flush and reset both return to an all-zero bubble
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state  <= ST_EMPTY;
            r_m_ctrl <= '0;
            r_m_data <= '0;
            r_m_dst  <= '0;
            r_s_ctrl <= '0;
            r_s_data <= '0;
            r_s_dst  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ld_m_in) begin
                r_m_ctrl <= in_ctrl;
                r_m_data <= in_data;
                r_m_dst  <= in_dst;
            end else if (w_m_from_s) begin
                r_m_ctrl <= r_s_ctrl;
                r_m_data <= r_s_data;
                r_m_dst  <= r_s_dst;
            end
            if (w_ld_s_in) begin
                r_s_ctrl <= in_ctrl;
                r_s_data <= in_data;
                r_s_dst  <= in_dst;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Saturating counters; flush deliberately leaves them alone
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (!out_valid && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized bench for pipe_stage_skid against a queue-based reference model.
// Counter checks are active when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_skid;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    typedef struct packed {
        logic [1:0]  c;
        logic [15:0] d;
        logic [2:0]  t;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ctrl;
    logic [15:0] in_data;
    logic [2:0]  in_dst;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ctrl;
    logic [15:0] out_data;
    logic [2:0]  out_dst;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;
`endif

    int    n_total;
    int    n_bad;
    beat_t q[$];
    beat_t hold;
    int    m_stall;
    int    m_bubble;

    pipe_stage_skid #(
        .CTRL_W(2),
        .DATA_W(16),
        .DST_W (3),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .in_dst    (in_dst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .out_dst   (out_dst)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Model: a FIFO of at most two beats, front is what downstream sees
    task automatic model_step();
        bit ir;
        bit ov;
        bit acc;
        bit drn;
        ir  = (q.size() < 2);
        ov  = (q.size() > 0);
        acc = in_valid && ir;
        drn = ov && out_ready;
        if (rst) begin
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if (ov && !out_ready && m_stall < SAT) m_stall++;
            if (!ov && m_bubble < SAT) m_bubble++;
        end
        if (rst || flush) begin
            q.delete();
            hold = '0;
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back({in_ctrl, in_data, in_dst});
            if (q.size() > 0) hold = q[0];
        end
    endtask

    task automatic check_all();
        bit ev;
        ev = (q.size() > 0);
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_ctrl", 32'(out_ctrl), ev ? 32'(q[0].c) : 32'd0);
        chk("out_data", 32'(out_data), 32'(hold.d));
        chk("out_dst", 32'(out_dst), 32'(hold.t));
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("bubble_cnt", 32'(bubble_cnt), 32'(m_bubble));
`endif
    endtask

    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [1:0] c, input logic [15:0] d,
                       input logic [2:0] t, input logic ordy);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        in_dst    = t;
        out_ready = ordy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        n_total  = 0;
        n_bad    = 0;
        hold     = '0;
        m_stall  = 0;
        m_bubble = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_ctrl = '0; in_data = '0; in_dst = '0; out_ready = 1'b0;
        @(negedge clk);

        // reset
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_data", 32'(out_data), 0);

        // full-rate stream
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 2'b11, 16'(16'h0102 + i), 3'(i + 1), 1);
            chk("stream_data", 32'(out_data), 32'(16'h0102 + i));
            chk("stream_dst", 32'(out_dst), 32'(i + 1));
            chk("stream_valid", 32'(out_valid), 1);
        end
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("drain_ctrl", 32'(out_ctrl), 0);
        chk("drain_hold", 32'(out_data), 32'h0105);

        // skid fill and ordered drain
        cyc(0, 0, 1, 2'b01, 16'hAAAA, 3'd5, 0);
        chk("skid_m", 32'(out_data), 32'hAAAA);
        cyc(0, 0, 1, 2'b10, 16'hBBBB, 3'd6, 0);
        chk("skid_full", 32'(in_ready), 0);
        chk("skid_hold_m", 32'(out_data), 32'hAAAA);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("skid_second", 32'(out_data), 32'hBBBB);
        chk("skid_ready", 32'(in_ready), 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("skid_empty", 32'(out_valid), 0);

        // flush while TWO
        cyc(0, 0, 1, 2'b11, 16'h1111, 3'd1, 0);
        cyc(0, 0, 1, 2'b11, 16'h2222, 3'd2, 0);
        cyc(0, 1, 1, 2'b11, 16'h3333, 3'd3, 0);
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_data", 32'(out_data), 0);
        chk("flush_ready", 32'(in_ready), 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("flush_gone", 32'(out_valid), 0);

        // reset while TWO
        cyc(0, 0, 1, 2'b01, 16'h4444, 3'd4, 0);
        cyc(0, 0, 1, 2'b01, 16'h5555, 3'd5, 0);
        cyc(1, 0, 1, 2'b01, 16'h6666, 3'd6, 0);
        chk("mrst_ready", 32'(in_ready), 1);
        chk("mrst_valid", 32'(out_valid), 0);
        cyc(0, 0, 1, 2'b10, 16'h1234, 3'd7, 1);
        chk("mrst_pass", 32'(out_data), 32'h1234);
        cyc(0, 0, 0, 0, 0, 0, 1);

`ifdef PIPE_STAGE_PERF_EN
        // stall saturation; flush must not clear counts
        cyc(0, 0, 1, 2'b01, 16'h7777, 3'd1, 0);
        for (int i = 0; i < 20; i++)
            cyc(0, 0, 0, 0, 0, 0, 0);
        chk("stall_sat", 32'(stall_cnt), 32'(SAT));
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("stall_flush", 32'(stall_cnt), 32'(SAT));
`endif

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 149) == 0),
                ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 9) < 7),
                2'($urandom), 16'($urandom), 3'($urandom),
                ($urandom_range(0, 9) < 6));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
